hilo_muldiv_sequencer: RTL and testbench
========================================

Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller for the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MADD/MSUB from EX and runs an iterative radix-2 shift-add multiply or restoring divide on a private 64-bit datapath.
- Owns the HI/LO registers, so MTHI/MTLO/MFHI/MFLO all go through this block.
- Raises a pipeline stall while a result is pending.

Parameters:
- ITER, 32, iteration count per operation; equals the operand width.

Ports:
- Clk  in  1  clock, rising-edge.
- Reset  in  1  synchronous, active-high; sampled on the Clk rising edge.
- StartIn  in  1  EX holds a mul/div op this cycle.
- OpIn  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; 11x is a no-op.
- ReadData1In  in  32  rs operand: multiplicand or dividend.
- ReadData2In  in  32  rt operand: multiplier or divisor.
- HiLoReadIn  in  1  MFHI/MFLO in EX.
- HiWriteIn  in  1  MTHI in EX.
- LoWriteIn  in  1  MTLO in EX.
- WriteDataIn  in  32  MTHI/MTLO data.
- FlushIn  in  1  kill the in-flight op (branch/exception squash).
- StallOut  out  1  freeze IF/ID/EX.
- BusyOut  out  1  operation in progress.
- DoneOut  out  1  one-cycle completion pulse.
- DivZeroOut  out  1  pulses with DoneOut on a zero divisor.
- HIRegOutput  out  32  HI register.
- LORegOutput  out  32  LO register.

Behaviour:
- Reset:
  - State goes to IDLE.
  - HI, LO and the internal accumulator, shift and count registers all clear to 0.
  - Every output is 0.
  - Reset has priority over everything, including mid-operation.
- States are IDLE, MUL, DIV, FIX and DONE.
- IDLE, when StartIn=1 and OpIn is valid (accept cycle c0):
  - Latch the operand magnitudes. Signed ops take the two's-complement absolute value; MULTU/DIVU take operands as-is.
  - Latch the result-sign bits and the op.
  - Load the counter with ITER.
  - Next state is MUL (ops 000/001/100/101) or DIV (010/011).
  - DIV/DIVU with ReadData2In=0 go straight to DONE with DivZeroOut=1; HI/LO are unchanged.
- MUL, one iteration per cycle:
  - If multiplier bit0=1, add the multiplicand to the upper product half.
  - Shift the 65-bit carry|product right by 1.
  - Decrement the counter; at 1, go to FIX.
- DIV, one iteration per cycle:
  - Shift the remainder:quotient left by 1 and trial-subtract the divisor.
  - If the result is non-negative, keep it and set quotient bit0=1.
  - Decrement the counter; at 1, go to FIX.
- FIX, one cycle; HI/LO are written at the end of this cycle:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - MADD/MSUB: HI:LO <= HI:LO ± signed product, 64-bit wrap-around, no overflow flag.
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- DONE, one cycle: DoneOut=1, then IDLE.
- Latency:
  - Accept at c0, iterations c1..c32, FIX at c33, DONE at c34.
  - New HI/LO are visible on HIRegOutput/LORegOutput from c34.
  - A new op can be accepted at c35.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0 (wraps, no trap).
- BusyOut is 1 in MUL, DIV and FIX; 0 in IDLE and DONE.
- StallOut is combinational: BusyOut & (StartIn | HiLoReadIn | HiWriteIn | LoWriteIn). Independent instructions proceed while busy.
- MTHI/MTLO:
  - In IDLE or DONE, write HI/LO at the next edge.
  - While busy they stall and complete after DONE.
  - If asserted in the same IDLE cycle as an accepted StartIn, the move is ignored and StartIn wins; decode never issues both.
- StartIn with OpIn=11x is ignored; no state change.
- FlushIn=1 in MUL, DIV or FIX:
  - Return to IDLE at the next edge.
  - HI/LO unchanged, no DoneOut.
  - FlushIn in IDLE or DONE has no effect.
  - FlushIn is subordinate to Reset.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: in MUL, if the remaining multiplier shift bits are all zero after at least one iteration, the product is aligned by the remaining counter amount in a single shift and the next state is FIX. Example: MULTU x*1 reaches DONE at c3.
- Undefined: every multiply takes the full ITER iterations. Divide latency is unaffected either way.

Test Plan:
- Reset, then MULTU 3*5 at c0 -> BusyOut c1..c33, DoneOut at c34 only, HI=0x00000000, LO=0x0000000F.
- MULT 0xFFFFFFFE*3, then MADD 2*2 -> after MULT, HI:LO=0xFFFFFFFF_FFFFFFFA; after MADD, HI:LO=0xFFFFFFFF_FFFFFFFE.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 10/0 with HI=0x11, LO=0x22 -> DONE at c1 with DivZeroOut=DoneOut=1; HI=0x11, LO=0x22 unchanged.
- MFHI (HiLoReadIn=1) held from c5 of a MULTU -> StallOut=1 c5..c33 and 0 at c34; an unrelated cycle with all requests low gives StallOut=0 while busy.
- FlushIn at c10 of DIVU -> IDLE at c11, no DoneOut, HI/LO unchanged; Reset at c20 of MULT -> HI=LO=0, IDLE.

Source files
------------

// File: rtl/hilo_muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer handshake, HI/LO move and status bundle.
interface hilo_muldiv_sequencer_if;
  logic        StartIn;
  logic [2:0]  OpIn;
  logic [31:0] ReadData1In;
  logic [31:0] ReadData2In;
  logic        HiLoReadIn;
  logic        HiWriteIn;
  logic        LoWriteIn;
  logic [31:0] WriteDataIn;
  logic        FlushIn;
  logic        StallOut;
  logic        BusyOut;
  logic        DoneOut;
  logic        DivZeroOut;
  logic [31:0] HIRegOutput;
  logic [31:0] LORegOutput;

  modport master (
    output StartIn, OpIn, ReadData1In, ReadData2In, HiLoReadIn, HiWriteIn,
           LoWriteIn, WriteDataIn, FlushIn,
    input  StallOut, BusyOut, DoneOut, DivZeroOut, HIRegOutput, LORegOutput
  );

  modport slave (
    input  StartIn, OpIn, ReadData1In, ReadData2In, HiLoReadIn, HiWriteIn,
           LoWriteIn, WriteDataIn, FlushIn,
    output StallOut, BusyOut, DoneOut, DivZeroOut, HIRegOutput, LORegOutput
  );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide sequencer owning HI/LO.
// Optional macro MULDIV_EARLY_TERM_EN: finish a multiply early once the remaining multiplier bits are zero.
module hilo_muldiv_sequencer #(
  parameter int unsigned ITER = 32
) (
  input logic                   Clk,
  input logic                   Reset,
  hilo_muldiv_sequencer_if.slave bus
);

  localparam int unsigned W    = 32;
  localparam int unsigned CntW = $clog2(ITER + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL  = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMadd  = 3'b100;
  localparam logic [2:0] OpMsub  = 3'b101;

  logic [2:0]      state, stateNext;
  logic [2*W-1:0]  acc, accNext;
  logic [W-1:0]    opnd, opndNext;
  logic [CntW-1:0] cnt, cntNext;
  logic [2:0]      opReg, opNext;
  logic            negRes, negNext;
  logic            remNeg, remNegNext;
  logic [W-1:0]    hiReg, hiNext;
  logic [W-1:0]    loReg, loNext;
  logic            busyReg, doneReg, divZeroReg, divZeroNext;

  logic            opValid, isDivOp, sgnOp, accept, flushHit;
  logic [W-1:0]    absA, absB;
  logic [W:0]      mulSum;
  logic [2*W-1:0]  mulStep;
  logic [2*W:0]    divShift;
  logic [W:0]      divTrial;
  logic [2*W-1:0]  prodS;
  logic [2*W-1:0]  hiLoSum;

`ifdef MULDIV_EARLY_TERM_EN
  logic [CntW-1:0] remaining;
  logic [W-1:0]    remMask;
`endif

  // State and datapath registers; Reset dominates everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      opReg      <= '0;
      negRes     <= 1'b0;
      remNeg     <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      state      <= stateNext;
      acc        <= accNext;
      opnd       <= opndNext;
      cnt        <= cntNext;
      opReg      <= opNext;
      negRes     <= negNext;
      remNeg     <= remNegNext;
      hiReg      <= hiNext;
      loReg      <= loNext;
      busyReg    <= (stateNext == MUL) || (stateNext == DIV) || (stateNext == FIX);
      doneReg    <= (stateNext == DONE);
      divZeroReg <= divZeroNext;
    end
  end

  // Next-state, iteration step and HI/LO update.
  always_comb begin
    stateNext   = state;
    accNext     = acc;
    opndNext    = opnd;
    cntNext     = cnt;
    opNext      = opReg;
    negNext     = negRes;
    remNegNext  = remNeg;
    hiNext      = hiReg;
    loNext      = loReg;
    divZeroNext = 1'b0;

    opValid  = ~(bus.OpIn[2] & bus.OpIn[1]);
    isDivOp  = (bus.OpIn == OpDiv) || (bus.OpIn == OpDivu);
    sgnOp    = (bus.OpIn == OpMult) || (bus.OpIn == OpDiv) || bus.OpIn[2];
    accept   = (state == IDLE) && bus.StartIn && opValid;
    flushHit = bus.FlushIn;
    absA     = (sgnOp && bus.ReadData1In[W-1]) ? W'(-bus.ReadData1In) : bus.ReadData1In;
    absB     = (sgnOp && bus.ReadData2In[W-1]) ? W'(-bus.ReadData2In) : bus.ReadData2In;

    mulSum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : (W+1)'(0));
    mulStep  = {mulSum, acc[W-1:1]};
    divShift = {acc, 1'b0};
    divTrial = divShift[2*W:W] - {1'b0, opnd};
    prodS    = negRes ? (2*W)'(-acc) : acc;
    hiLoSum  = (opReg == OpMsub) ? ({hiReg, loReg} - prodS) : ({hiReg, loReg} + prodS);

`ifdef MULDIV_EARLY_TERM_EN
    remaining = CntW'(cnt - CntW'(1));
    remMask   = (W'(1) << remaining) - W'(1);
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          if (isDivOp && (bus.ReadData2In == '0)) begin
            stateNext   = DONE;
            divZeroNext = 1'b1;
          end else begin
            opNext     = bus.OpIn;
            negNext    = sgnOp & (bus.ReadData1In[W-1] ^ bus.ReadData2In[W-1]);
            remNegNext = sgnOp & bus.ReadData1In[W-1];
            opndNext   = isDivOp ? absB : absA;
            accNext    = {{W{1'b0}}, (isDivOp ? absA : absB)};
            cntNext    = CntW'(ITER);
            stateNext  = isDivOp ? DIV : MUL;
          end
        end else begin
          if (bus.HiWriteIn) hiNext = bus.WriteDataIn;
          if (bus.LoWriteIn) loNext = bus.WriteDataIn;
        end
      end
      MUL: begin
        accNext = mulStep;
        cntNext = CntW'(cnt - CntW'(1));
        if (cnt == CntW'(1)) stateNext = FIX;
`ifdef MULDIV_EARLY_TERM_EN
        else if ((mulStep[W-1:0] & remMask) == '0) begin
          accNext   = mulStep >> remaining;
          stateNext = FIX;
        end
`endif
        if (flushHit) stateNext = IDLE;
      end
      DIV: begin
        if (!divTrial[W]) accNext = {divTrial[W-1:0], divShift[W-1:1], 1'b1};
        else              accNext = divShift[2*W-1:0];
        cntNext = CntW'(cnt - CntW'(1));
        if (cnt == CntW'(1)) stateNext = FIX;
        if (flushHit) stateNext = IDLE;
      end
      FIX: begin
        stateNext = DONE;
        case (opReg)
          OpMult, OpMultu: {hiNext, loNext} = prodS;
          OpMadd, OpMsub:  {hiNext, loNext} = hiLoSum;
          OpDiv, OpDivu: begin
            loNext = negRes ? W'(-acc[W-1:0]) : acc[W-1:0];
            hiNext = remNeg ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
          end
          default: ;
        endcase
        // A squash in the writeback cycle still leaves HI/LO untouched.
        if (flushHit) begin
          stateNext = IDLE;
          hiNext    = hiReg;
          loNext    = loReg;
        end
      end
      DONE: begin
        stateNext = IDLE;
        if (bus.HiWriteIn) hiNext = bus.WriteDataIn;
        if (bus.LoWriteIn) loNext = bus.WriteDataIn;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.BusyOut     = busyReg;
  assign bus.DoneOut     = doneReg;
  assign bus.DivZeroOut  = divZeroReg;
  assign bus.HIRegOutput = hiReg;
  assign bus.LORegOutput = loReg;
  assign bus.StallOut    = busyReg & (bus.StartIn | bus.HiLoReadIn | bus.HiWriteIn | bus.LoWriteIn);

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed self-checking bench for hilo_muldiv_sequencer (default build, full-length multiply).
module tb_hilo_muldiv_sequencer;

  logic Clk;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  hilo_muldiv_sequencer_if bus ();

  hilo_muldiv_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1ns after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present an op for one cycle (c0); returns at the c1 sample point.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.StartIn     = 1'b1;
    bus.OpIn        = op;
    bus.ReadData1In = a;
    bus.ReadData2In = b;
    step();
    bus.StartIn = 1'b0;
  endtask

  // Wait (bounded) for DoneOut; cyc is the cycle index where it was seen.
  task automatic waitDone(input string tag, output int cyc);
    cyc = 1;
    while (!bus.DoneOut && cyc < 200) begin
      step();
      cyc++;
    end
    checkVal({tag, "_done_seen"}, 64'(bus.DoneOut), 64'd1);
  endtask

  function automatic logic [63:0] hiLo();
    return {bus.HIRegOutput, bus.LORegOutput};
  endfunction

  initial begin
    int cyc;
    int doneCount;

    Reset           = 1'b1;
    bus.StartIn     = 1'b0;
    bus.OpIn        = 3'b000;
    bus.ReadData1In = '0;
    bus.ReadData2In = '0;
    bus.HiLoReadIn  = 1'b0;
    bus.HiWriteIn   = 1'b0;
    bus.LoWriteIn   = 1'b0;
    bus.WriteDataIn = '0;
    bus.FlushIn     = 1'b0;
    step();
    step();
    Reset = 1'b0;

    checkVal("rst_busy", 64'(bus.BusyOut), 64'd0);
    checkVal("rst_done", 64'(bus.DoneOut), 64'd0);
    checkVal("rst_divzero", 64'(bus.DivZeroOut), 64'd0);
    checkVal("rst_stall", 64'(bus.StallOut), 64'd0);
    checkVal("rst_hilo", hiLo(), 64'd0);

    // MULTU 3*5 with cycle-exact busy/done profile.
    issue(3'b001, 32'd3, 32'd5);
    for (int c = 1; c <= 34; c++) begin
      checkVal($sformatf("multu_busy_c%0d", c), 64'(bus.BusyOut), 64'(c <= 33));
      checkVal($sformatf("multu_done_c%0d", c), 64'(bus.DoneOut), 64'(c == 34));
      if (c == 34) checkVal("multu_3x5", hiLo(), 64'h00000000_0000000F);
      if (c < 34) step();
    end
    step();
    checkVal("multu_c35_idle", 64'({bus.BusyOut, bus.DoneOut}), 64'd0);

    // MULT -2*3 then MADD 2*2.
    issue(3'b000, 32'hFFFFFFFE, 32'd3);
    waitDone("mult", cyc);
    checkVal("mult_latency", 64'(cyc), 64'd34);
    checkVal("mult_neg", hiLo(), 64'hFFFFFFFF_FFFFFFFA);
    step();
    issue(3'b100, 32'd2, 32'd2);
    waitDone("madd", cyc);
    checkVal("madd_acc", hiLo(), 64'hFFFFFFFF_FFFFFFFE);
    step();

    // MSUB 3*(-1): HI:LO - (-3) = ...FFFE + 3 = 1.
    issue(3'b101, 32'd3, 32'hFFFFFFFF);
    waitDone("msub", cyc);
    checkVal("msub_acc", hiLo(), 64'h00000000_00000001);
    step();

    // Signed divide: -7/2 and the overflow case.
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    waitDone("div_m7", cyc);
    checkVal("div_m7_latency", 64'(cyc), 64'd34);
    checkVal("div_m7", hiLo(), 64'hFFFFFFFF_FFFFFFFD);
    step();
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    waitDone("div_ovf", cyc);
    checkVal("div_ovf", hiLo(), 64'h00000000_80000000);
    step();

    // DIVU 100/7 = 14 r 2.
    issue(3'b011, 32'd100, 32'd7);
    waitDone("divu", cyc);
    checkVal("divu_100_7", hiLo(), 64'h00000002_0000000E);
    step();

    // MTHI/MTLO in IDLE, then DIVU by zero.
    bus.HiWriteIn   = 1'b1;
    bus.WriteDataIn = 32'h11;
    step();
    bus.HiWriteIn   = 1'b0;
    bus.LoWriteIn   = 1'b1;
    bus.WriteDataIn = 32'h22;
    step();
    bus.LoWriteIn = 1'b0;
    checkVal("mt_hilo", hiLo(), 64'h00000011_00000022);
    issue(3'b011, 32'd10, 32'd0);
    checkVal("dz_done_c1", 64'(bus.DoneOut), 64'd1);
    checkVal("dz_flag_c1", 64'(bus.DivZeroOut), 64'd1);
    checkVal("dz_busy_c1", 64'(bus.BusyOut), 64'd0);
    checkVal("dz_hilo", hiLo(), 64'h00000011_00000022);
    step();
    checkVal("dz_pulse_end", 64'({bus.DoneOut, bus.DivZeroOut}), 64'd0);

    // Reserved op 11x is ignored.
    issue(3'b110, 32'd1, 32'd1);
    checkVal("nop_busy", 64'(bus.BusyOut), 64'd0);
    step();
    checkVal("nop_done", 64'(bus.DoneOut), 64'd0);

    // MFHI held from c5 of a MULTU 7*9.
    issue(3'b001, 32'd7, 32'd9);
    for (int c = 1; c <= 34; c++) begin
      bus.HiLoReadIn = (c >= 5);
      #1;
      if (c == 2) checkVal("stall_indep", 64'(bus.StallOut), 64'd0);
      if (c >= 5) checkVal($sformatf("stall_mfhi_c%0d", c), 64'(bus.StallOut), 64'(c <= 33));
      if (c == 34) checkVal("multu_7x9", hiLo(), 64'd63);
      if (c < 34) step();
    end
    bus.HiLoReadIn = 1'b0;
    step();

    // Flush a DIVU at c10.
    issue(3'b011, 32'd1000, 32'd3);
    repeat (9) step();
    bus.FlushIn = 1'b1;
    step();
    bus.FlushIn = 1'b0;
    checkVal("flush_busy_c11", 64'(bus.BusyOut), 64'd0);
    doneCount = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.DoneOut) doneCount++;
      step();
    end
    checkVal("flush_no_done", 64'(doneCount), 64'd0);
    checkVal("flush_hilo", hiLo(), 64'd63);

    // Reset at c20 of a MULT.
    issue(3'b000, 32'd5, 32'd6);
    repeat (19) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checkVal("mrst_busy", 64'(bus.BusyOut), 64'd0);
    checkVal("mrst_hilo", hiLo(), 64'd0);
    doneCount = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.DoneOut) doneCount++;
      step();
    end
    checkVal("mrst_no_done", 64'(doneCount), 64'd0);

    // Largest unsigned operands.
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone("multu_max", cyc);
    checkVal("multu_max", hiLo(), 64'hFFFFFFFE_00000001);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
